// File: rtl/stopwatch_counter.sv
// stopwatch_counter: debounced start/pause/clear stopwatch producing one 4-bit digit.
// Define STOPWATCH_LAP_EN to make buttons[1] toggle a lap hold while running.

module stopwatch_button #(
    parameter int DEBOUNCE_CYCLES = 270_000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn,
    output logic press
);
    localparam int DW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [DW-1:0] CNT_LAST = DW'(DEBOUNCE_CYCLES - 1);

    logic          sync1, sync2, db, db_d;
    logic [DW-1:0] cnt;

    // Released level (1) out of reset, so reset itself never looks like a press.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= 1'b1;
            sync2 <= 1'b1;
            db    <= 1'b1;
            db_d  <= 1'b1;
            cnt   <= '0;
            press <= 1'b0;
        end else begin
            sync1 <= btn;
            sync2 <= sync1;
            db_d  <= db;
            press <= db_d & ~db;
            if (sync2 != db) begin
                if (cnt == CNT_LAST) begin
                    db  <= sync2;
                    cnt <= '0;
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end else begin
                cnt <= '0;
            end
        end
    end
endmodule

module stopwatch_counter #(
    parameter int CLK_HZ          = 27_000_000,
    parameter int TICK_HZ         = 1,
    parameter int DEBOUNCE_CYCLES = 270_000,
    parameter int COUNT           = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] buttons,
    output logic [3:0] number,
    output logic       running,
    output logic       tick,
    output logic       wrap,
    output logic       lap
);
    localparam int PERIOD = CLK_HZ / TICK_HZ;
    localparam int PW     = (PERIOD > 1) ? $clog2(PERIOD) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(PERIOD - 1);
    localparam logic [3:0]    COUNT_LAST = 4'(COUNT - 1);

    // RUN is the only state with bit 0 set, so running comes straight off a flop.
    typedef enum logic [1:0] {
        S_IDLE  = 2'b00,
        S_RUN   = 2'b01,
        S_PAUSE = 2'b10
    } state_t;

    state_t        state, state_nxt;
    logic [1:0]    press;
    logic          clr, cnt_en;
    logic [PW-1:0] presc, presc_nxt;
    logic [3:0]    count, count_nxt;
    logic          tick_nxt, wrap_nxt;
`ifdef STOPWATCH_LAP_EN
    logic          lap_tgl, lap_nxt;
`endif

    stopwatch_button #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_btn [1:0] (
        .clk   (clk),
        .rst_n (rst_n),
        .btn   (buttons),
        .press (press)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nxt;
    end

    // Clear/lap button wins over start/pause when both land on the same cycle.
    always_comb begin
        state_nxt = state;
        if (press[1]) begin
`ifdef STOPWATCH_LAP_EN
            if (state != S_RUN) state_nxt = S_IDLE;
`else
            state_nxt = S_IDLE;
`endif
        end else if (press[0]) begin
            case (state)
                S_IDLE:  state_nxt = S_RUN;
                S_RUN:   state_nxt = S_PAUSE;
                S_PAUSE: state_nxt = S_RUN;
                default: state_nxt = S_IDLE;
            endcase
        end
    end

    always_comb begin
        clr    = (state_nxt == S_IDLE);
        cnt_en = (state == S_RUN) && !clr;
`ifdef STOPWATCH_LAP_EN
        lap_tgl = press[1] && (state == S_RUN);
`endif
    end

    assign running = state[0];

    // Prescaler is simply not advanced in PAUSE, so resume picks up mid-period.
    always_comb begin
        presc_nxt = presc;
        count_nxt = count;
        tick_nxt  = 1'b0;
        wrap_nxt  = 1'b0;
        if (clr) begin
            presc_nxt = '0;
            count_nxt = '0;
        end else if (cnt_en) begin
            if (presc == PRESC_LAST) begin
                presc_nxt = '0;
                tick_nxt  = 1'b1;
                if (count == COUNT_LAST) begin
                    count_nxt = '0;
                    wrap_nxt  = 1'b1;
                end else begin
                    count_nxt = count + 1'b1;
                end
            end else begin
                presc_nxt = presc + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc <= '0;
            count <= '0;
            tick  <= 1'b0;
            wrap  <= 1'b0;
        end else begin
            presc <= presc_nxt;
            count <= count_nxt;
            tick  <= tick_nxt;
            wrap  <= wrap_nxt;
        end
    end

`ifdef STOPWATCH_LAP_EN
    always_comb begin
        lap_nxt = lap;
        if (clr)          lap_nxt = 1'b0;
        else if (lap_tgl) lap_nxt = ~lap;
    end

    // While held, number keeps whatever it showed when the hold went on.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lap    <= 1'b0;
            number <= '0;
        end else begin
            lap <= lap_nxt;
            if (!lap_nxt) number <= count_nxt;
        end
    end
`else
    assign lap = 1'b0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) number <= '0;
        else        number <= count_nxt;
    end
`endif
endmodule

// File: tb/tb_stopwatch_counter.sv
// Scoreboard bench for stopwatch_counter: expected tick values are queued ahead of
// stimulus and popped by a negedge monitor; timing checks use recorded edge cycles.
module tb_stopwatch_counter;
    localparam int PERIOD = 10;
    localparam int COUNT  = 16;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [1:0] buttons = 2'b11;
    logic [3:0] number;
    logic       running, tick, wrap, lap;

    stopwatch_counter #(
        .CLK_HZ(100), .TICK_HZ(10), .DEBOUNCE_CYCLES(4), .COUNT(COUNT)
    ) dut (
        .clk(clk), .rst_n(rst_n), .buttons(buttons),
        .number(number), .running(running), .tick(tick), .wrap(wrap), .lap(lap)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] num;
        logic       wrp;
    } exp_t;

    exp_t       exp_q[$];
    int         n_vec = 0, n_err = 0;
    int         cyc = 0;
    int         tick_cnt = 0, tick_cyc = -1000, rise_cyc = -1000, fall_cyc = -1000;
    int         exp_num = 0;
    bit         holding = 1'b0;
    logic [3:0] hold_val = '0;
    logic       prev_run = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d want %0d (cyc %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic press_btn(logic [1:0] mask, int hold);
        buttons = ~mask;
        repeat (hold) step();
        buttons = 2'b11;
    endtask

    task automatic push_ticks(int n);
        exp_t e;
        for (int i = 0; i < n; i++) begin
            exp_num = (exp_num + 1) % COUNT;
            e.num = holding ? hold_val : 4'(exp_num);
            e.wrp = (exp_num == 0);
            exp_q.push_back(e);
        end
    endtask

    task automatic wait_ticks(int n);
        int target;
        int guard;
        target = tick_cnt + n;
        guard  = 0;
        while (tick_cnt < target && guard < 20 * PERIOD * n) begin
            step();
            guard++;
        end
        if (tick_cnt < target) chk("tick_timeout", tick_cnt, target);
    endtask

    initial forever begin
        exp_t e;
        @(negedge clk);
        if (running && !prev_run) rise_cyc = cyc;
        if (!running && prev_run) fall_cyc = cyc;
        prev_run = running;
        if (tick) begin
            tick_cnt++;
            tick_cyc = cyc;
            if (exp_q.size() == 0) begin
                chk("tick_unexp", tick, 1'b0);
            end else begin
                e = exp_q.pop_front();
                chk("tick_num", number, e.num);
                chk("tick_wrap", wrap, e.wrp);
            end
        end else if (wrap) begin
            chk("wrap_stray", wrap, 1'b0);
        end
    end

    initial begin
        int x, t, n0;

        // reset state
        repeat (3) step();
        chk("rst_num", number, 0);
        chk("rst_run", running, 0);
        chk("rst_tick", tick, 0);
        chk("rst_wrap", wrap, 0);
        chk("rst_lap", lap, 0);
        rst_n = 1'b1;

        // bounce shorter than the debounce window, then idle
        for (int i = 0; i < 5; i++) begin
            buttons[0] = 1'b0; repeat (2) step();
            buttons[0] = 1'b1; repeat (2) step();
        end
        repeat (50) step();
        chk("idle_run", running, 0);
        chk("idle_num", number, 0);
        chk("idle_ticks", tick_cnt, 0);

        // start, full cycle through wrap
        push_ticks(16);
        x = cyc;
        press_btn(2'b01, 12);
        chk("start_lat", rise_cyc - x, 8);
        wait_ticks(1);
        chk("tick1_lat", tick_cyc - rise_cyc, PERIOD);
        wait_ticks(15);
        step();
        chk("wrap_pulse", wrap, 0);
        chk("held_one_evt", running, 1);

        // pause 5 cycles past a tick, resume
        push_ticks(2);
        wait_ticks(1);
        t = tick_cnt;
        repeat (PERIOD - 3) step();
        press_btn(2'b01, 10);
        chk("pause_ticks", tick_cnt - t, 1);
        chk("pause_acc", fall_cyc - tick_cyc, 5);
        n0 = int'(number);
        repeat (30) step();
        chk("pause_val", number, exp_num);
        chk("pause_hold", number, n0);
        chk("pause_run", running, 0);
        push_ticks(1);
        x = cyc;
        press_btn(2'b01, 10);
        chk("resume_rise", rise_cyc - x, 8);
        wait_ticks(1);
        chk("resume_lat", tick_cyc - rise_cyc, 5);

`ifdef STOPWATCH_LAP_EN
        // lap hold at 3 across 3 ticks
        press_btn(2'b10, 8);
        chk("lap_on", lap, 1);
        chk("lap_num", number, 3);
        holding  = 1'b1;
        hold_val = 4'd3;
        push_ticks(3);
        wait_ticks(3);
        chk("lap_frozen", number, 3);
        press_btn(2'b10, 8);
        holding = 1'b0;
        chk("lap_off", lap, 0);
        chk("lap_release", number, 6);
        // both buttons in RUN: press1 wins and toggles hold
        push_ticks(1);
        press_btn(2'b11, 8);
        chk("both_lap", lap, 1);
        chk("both_run", running, 1);
        chk("both_num", number, 7);
`else
        // both buttons in RUN: clear wins
        x = cyc;
        press_btn(2'b11, 10);
        exp_num = 0;
        chk("clr_fall", fall_cyc - x, 8);
        chk("clr_run", running, 0);
        chk("clr_num", number, 0);
        repeat (20) step();
        chk("clr_stay", number, 0);
        chk("lap_tied", lap, 0);
        press_btn(2'b01, 9);
        chk("rerun", running, 1);
`endif

        // async reset mid-run with start button held through release
        rst_n   = 1'b0;
        buttons = 2'b10;
        #1;
        chk("arst_run", running, 0);
        chk("arst_num", number, 0);
        chk("arst_lap", lap, 0);
        exp_q.delete();
        exp_num = 0;
        holding = 1'b0;
        repeat (3) step();
        rst_n = 1'b1;
        x = cyc;
        repeat (12) step();
        buttons = 2'b11;
        chk("rst_hold_lat", rise_cyc - x, 8);
        push_ticks(1);
        wait_ticks(1);
        chk("rst_tick_lat", tick_cyc - rise_cyc, PERIOD);
        chk("q_empty", exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/stopwatch_counter.md
# stopwatch_counter

Button-controlled run/pause/clear counter that produces the 4-bit digit value consumed by the seven-segment decoder, replacing the free-running seconds timer/number chain in the top level. It synchronises and debounces the two board buttons, runs a start/pause/clear state machine, prescales `clk` to a tick rate, and counts modulo `COUNT`. Optional lap-hold freezes the displayed value while counting continues.

## Interface
- `CLK_HZ`, 27_000_000, input clock frequency.
- `TICK_HZ`, 1, count rate; `PERIOD = CLK_HZ/TICK_HZ` (integer, ≥2).
- `DEBOUNCE_CYCLES`, 270_000, consecutive stable cycles required to accept a button level (≥1).
- `COUNT`, 16, counter modulus (2..16).
- `clk`  input  1  system clock; all logic on rising edge.
- `rst_n`  input  1  asynchronous, active-low reset.
- `buttons`  input  2  raw board buttons, active-low (0 = pressed); [0] start/pause, [1] clear/lap.
- `number`  output  4  displayed count, 0..COUNT-1, to seven-segment decoder.
- `running`  output  1  high in RUN state.
- `tick`  output  1  one-cycle pulse coincident with each internal count update.
- `wrap`  output  1  one-cycle pulse when internal count goes COUNT-1 -> 0 (coincides with `tick`).
- `lap`  output  1  high while lap hold is active (always 0 without `STOPWATCH_LAP_EN`).

## Operation
- Per button: 2-FF synchroniser (reset value 1), then debouncer holding `db` (reset 1). Counter increments each cycle sync2 != `db`, clears whenever they match; when the mismatch has persisted `DEBOUNCE_CYCLES` cycles, `db` takes the sync2 value and the counter clears.
- Press event = registered one-cycle pulse on `db` 1->0. Releases generate no event. Holding a button generates exactly one event.
- States: IDLE (count 0, prescaler 0), RUN, PAUSE.
- press0: IDLE->RUN, RUN->PAUSE, PAUSE->RUN.
- press1: any state -> IDLE (count, prescaler, lap cleared); see Configuration for RUN behaviour with lap enabled.
- press0 and press1 in the same cycle: press1 takes priority; press0 ignored.
- Prescaler counts 0..PERIOD-1 only in RUN; held (not cleared) in PAUSE; zeroed in IDLE. At PERIOD-1 in RUN it returns to 0, `tick` pulses, count increments; at COUNT-1 the count becomes 0 and `wrap` pulses.
- `number` = internal count, except while lap hold is active.

## Timing
- Reset (async assert, sync release): state IDLE; `number`=0, `running`=0, `tick`=0, `wrap`=0, `lap`=0; sync/debounce regs = 1 (released). Assertion mid-operation aborts everything immediately; no event generated by reset itself.
- Button held low through reset release: accepted as one press after normal debounce latency.
- Raw edge sampled at edge N: sync2 at N+1, `db` flips at N+1+DEBOUNCE_CYCLES, press pulse at N+2+DEBOUNCE_CYCLES, state/`running`/`lap` change at N+3+DEBOUNCE_CYCLES.
- Bounce shorter than `DEBOUNCE_CYCLES` produces no event and restarts the stability count.
- First `tick` after IDLE->RUN: exactly PERIOD cycles after the edge where `running` rises. After PAUSE->RUN: PERIOD minus cycles already accumulated before the pause.
- `tick`, `wrap`, `number` update on the same edge; all outputs registered.

## Configuration
- `STOPWATCH_LAP_EN` defined: press1 in RUN toggles lap hold instead of clearing. Hold on: `number` freezes at the current count, `lap`=1, counting continues internally. Hold off: `number` follows the count again, `lap`=0. press1 in PAUSE or IDLE clears to IDLE and drops hold. press0 -> PAUSE keeps hold state.
- Undefined: press1 always clears to IDLE; `lap` tied 0; no hold register.

## Test plan
(Params: CLK_HZ=100, TICK_HZ=10, DEBOUNCE_CYCLES=4, COUNT=16.)
- Reset then idle 50 cycles -> `number`=0, `running`=0, no `tick`.
- buttons[0] low at edge N, held -> `running`=1 at N+7; `tick` and `number`=1 at N+17; `number`=15 after 15 ticks, next tick `number`=0 with `wrap`=1 for one cycle.
- buttons[0] bouncing 0/1 every 2 cycles for 20 cycles, then released -> no state change.
- RUN 5 cycles past tick, press0 (PAUSE) 30 cycles, press0 again -> next `tick` 5 cycles after `running` re-rises; `number` unchanged during PAUSE.
- Both buttons pressed at the same edge while RUN -> IDLE, `number`=0, `running`=0.
- With `STOPWATCH_LAP_EN`: RUN at `number`=3, press1 -> `lap`=1, `number` stays 3 across 3 ticks; press1 -> `number`=6, `lap`=0.
